npc_mem_arbiter: RTL

- Shares the single data-memory port between the instruction-fetch requester (IFU, read-only) and the load/store requester (LSU, read/write).
- Sits between the core front/back end and the memory bridge.
- One outstanding transaction at a time, with a valid/ready request handshake, a one-cycle response pulse, round-robin grant and a response watchdog.

---
 rtl/npc_pkg.sv | 17 +
 rtl/npc_mem_arbiter_if.sv | 53 +++++
 rtl/npc_rr_arb2.sv | 35 +++
 rtl/npc_mem_arbiter.sv | 113 +++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared types and constants for the NPC memory-side blocks.
package npc_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_WAIT,
        ARB_RESP
    } arb_state_e;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    localparam logic [31:0] RESET_PC     = 32'h8000_0000;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/npc_mem_arbiter_if.sv
// Requester and memory-side handshake bundle of the memory arbiter.
interface npc_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                  ifu_req_valid;
    logic                  ifu_req_ready;
    logic [ADDR_W-1:0]     ifu_addr;
    logic                  ifu_resp_valid;
    logic [DATA_W-1:0]     ifu_resp_data;

    logic                  lsu_req_valid;
    logic                  lsu_req_ready;
    logic [ADDR_W-1:0]     lsu_addr;
    logic                  lsu_wen;
    logic [DATA_W-1:0]     lsu_wdata;
    logic [DATA_W/8-1:0]   lsu_wmask;
    logic                  lsu_resp_valid;
    logic [DATA_W-1:0]     lsu_resp_data;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_wen;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wmask;
    logic                  mem_resp_valid;
    logic [DATA_W-1:0]     mem_resp_data;

    logic                  timeout_err;

    // Arbiter side
    modport slave (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_data,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output timeout_err
    );

    // Requesters plus memory model side
    modport master (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_data,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  timeout_err
    );
endinterface

// File: rtl/npc_rr_arb2.sv
// Two-way round-robin grant; on a tie the requester not granted last wins.
module npc_rr_arb2
    import npc_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req_ifu,
    input  logic req_lsu,
    output logic gnt_valid_c,
    output logic gnt_owner_c
);

    logic last_grant;

    always_comb begin
        gnt_valid_c = en && (req_ifu || req_lsu);
        gnt_owner_c = OWN_IFU;
        if (req_ifu && req_lsu) begin
            gnt_owner_c = ~last_grant;
        end else if (req_lsu) begin
            gnt_owner_c = OWN_LSU;
        end
    end

    // Reset to IFU so the LSU wins the first tie
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant <= OWN_IFU;
        end else if (gnt_valid_c) begin
            last_grant <= gnt_owner_c;
        end
    end

endmodule

// File: rtl/npc_mem_arbiter.sv
// Shares one memory port between IFU and LSU; one outstanding transaction with a response watchdog.
module npc_mem_arbiter
    import npc_pkg::*;
#(
    parameter int unsigned         ADDR_W      = 32,
    parameter int unsigned         DATA_W      = 32,
    parameter int unsigned         TIMEOUT_CYC = 255,
    parameter logic [DATA_W-1:0]   ERR_DATA    = DATA_W'(ERR_DATA_DEF)
) (
    input  logic            clk,
    input  logic            reset,
    npc_mem_arbiter_if.slave bus
);

    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned MASK_W = DATA_W / 8;

    arb_state_e          state, state_nx;
    logic                owner;
    logic [ADDR_W-1:0]   addr_q;
    logic                wen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [MASK_W-1:0]   wmask_q;
    logic [DATA_W-1:0]   resp_data_q;
    logic                timeout_q;
    logic [CNT_W-1:0]    cnt;
    logic                gnt_valid_c;
    logic                gnt_owner_c;
    logic                timeout_hit_c;
    logic                lsu_store_c;

    npc_rr_arb2 u_rr (
        .clk         (clk),
        .reset       (reset),
        .en          ((state == ARB_IDLE) && reset),
        .req_ifu     (bus.ifu_req_valid),
        .req_lsu     (bus.lsu_req_valid),
        .gnt_valid_c (gnt_valid_c),
        .gnt_owner_c (gnt_owner_c)
    );

    assign timeout_hit_c = (state == ARB_WAIT) && !bus.mem_resp_valid
                           && (cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign lsu_store_c   = (gnt_owner_c == OWN_LSU) && bus.lsu_wen;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ARB_IDLE: if (gnt_valid_c)                          state_nx = ARB_REQ;
            ARB_REQ:  if (bus.mem_req_ready)                    state_nx = ARB_WAIT;
            ARB_WAIT: if (bus.mem_resp_valid || timeout_hit_c)  state_nx = ARB_RESP;
            ARB_RESP:                                           state_nx = ARB_IDLE;
            default:                                            state_nx = ARB_IDLE;
        endcase
    end

    // Request latch, watchdog counter and response capture
    always_ff @(posedge clk) begin
        if (!reset) begin
            owner       <= OWN_IFU;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            resp_data_q <= '0;
            timeout_q   <= 1'b0;
            cnt         <= '0;
        end else begin
            timeout_q <= 1'b0;
            if ((state == ARB_IDLE) && gnt_valid_c) begin
                owner   <= gnt_owner_c;
                addr_q  <= (gnt_owner_c == OWN_LSU) ? bus.lsu_addr : bus.ifu_addr;
                wen_q   <= lsu_store_c;
                wdata_q <= lsu_store_c ? bus.lsu_wdata : '0;
                wmask_q <= lsu_store_c ? bus.lsu_wmask : '0;
            end
            if ((state == ARB_REQ) && bus.mem_req_ready) begin
                cnt <= '0;
            end
            if (state == ARB_WAIT) begin
                cnt <= cnt + CNT_W'(1);
                if (bus.mem_resp_valid) begin
                    resp_data_q <= bus.mem_resp_data;
                end else if (timeout_hit_c) begin
                    resp_data_q <= ERR_DATA;
                    timeout_q   <= 1'b1;
                end
            end
        end
    end

    assign bus.ifu_req_ready  = gnt_valid_c && (gnt_owner_c == OWN_IFU);
    assign bus.lsu_req_ready  = gnt_valid_c && (gnt_owner_c == OWN_LSU);
    assign bus.ifu_resp_valid = (state == ARB_RESP) && (owner == OWN_IFU);
    assign bus.lsu_resp_valid = (state == ARB_RESP) && (owner == OWN_LSU);
    assign bus.ifu_resp_data  = resp_data_q;
    assign bus.lsu_resp_data  = resp_data_q;
    assign bus.mem_req_valid  = (state == ARB_REQ);
    assign bus.mem_addr       = addr_q;
    assign bus.mem_wen        = wen_q;
    assign bus.mem_wdata      = wdata_q;
    assign bus.mem_wmask      = wmask_q;
    assign bus.timeout_err    = timeout_q;

endmodule
